mux_dff_reg: RTL and testbench



---
 rtl/mac_pkg.sv | 13 +
 rtl/mux_dff_bit.sv | 29 ++
 rtl/mux_dff_reg.sv | 146 ++++++++++++++
 tb/tb_mux_dff_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC datapath: register mode encoding and unload FSM states.
package mac_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_SHL  = 2'b11;

    typedef logic [0:0] state_t;
    localparam state_t IDLE   = 1'b0;
    localparam state_t UNLOAD = 1'b1;

endpackage

// File: rtl/mux_dff_bit.sv
// Generalised single-bit cell: NUM_SRC:1 source mux with a bypass input, feeding one flop
// with synchronous active-high clear.
module mux_dff_bit #(
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SEL_W = $clog2(NUM_SRC)
) (
    input  logic               CLK,
    input  logic               CLR,
    input  logic [NUM_SRC-1:0] src,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load,
    input  logic               alt_d,
    output logic               d,
    output logic               q
);

    always_comb begin
        d = load ? src[sel] : alt_d;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mux_dff_reg.sv
// WIDTH-bit mux-select register with hold/load/shift modes and a counted bit-serial unload.
// Optional registered even-parity output enabled by defining MUXREG_PARITY_EN.
module mux_dff_reg
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic [NUM_SRC*WIDTH-1:0] src,
    input  logic [SEL_W-1:0]         sel_a,
    input  logic [SEL_W-1:0]         sel_b,
    input  logic                     sel_gate,
    input  logic [1:0]               mode,
    input  logic                     ser_in,
    input  logic                     unload,
    output logic [WIDTH-1:0]         q,
`ifdef MUXREG_PARITY_EN
    output logic                     parity,
`endif
    output logic                     ser_out,
    output logic                     ser_vld,
    output logic                     busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    logic [SEL_W-1:0] eff_sel;
    logic             load_en;
    logic             start;
    logic [WIDTH-1:0] alt_d;
    logic [WIDTH-1:0] q_next;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_vld_q, ser_vld_d;

    always_comb begin
        eff_sel    = sel_a | sel_b;
        eff_sel[0] = (sel_a[0] | sel_b[0]) & sel_gate;
    end

    // Mode only acts in IDLE and only when no unload is being started.
    always_comb begin
        load_en = 1'b0;
        alt_d   = q;
        if (state_q == IDLE && !unload) begin
            unique case (mode)
                MODE_LOAD: load_en = 1'b1;
                MODE_SHR:  alt_d = {ser_in, q[WIDTH-1:1]};
                MODE_SHL:  alt_d = {q[WIDTH-2:0], ser_in};
                default:   alt_d = q;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [NUM_SRC-1:0] bit_src;
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
            assign bit_src[k] = src[k*WIDTH + i];
        end
        mux_dff_bit #(
            .NUM_SRC(NUM_SRC)
        ) u_bit (
            .CLK  (CLK),
            .CLR  (CLR),
            .src  (bit_src),
            .sel  (eff_sel),
            .load (load_en),
            .alt_d(alt_d[i]),
            .d    (q_next[i]),
            .q    (q[i])
        );
    end

    // The start edge already presents bit 0, so cnt tracks the index of the visible pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        ser_out_d = 1'b0;
        ser_vld_d = 1'b0;
        start     = 1'b0;
        if (state_q == IDLE) begin
            start = unload;
        end else if (cnt_q == CntLast) begin
            state_d = IDLE;
            start   = unload;
        end else begin
            ser_out_d = buf_q[0];
            ser_vld_d = 1'b1;
            buf_d     = buf_q >> 1;
            cnt_d     = cnt_q + 1'b1;
        end
        if (start) begin
            state_d   = UNLOAD;
            cnt_d     = '0;
            ser_out_d = q[0];
            ser_vld_d = 1'b1;
            buf_d     = q >> 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            buf_q     <= '0;
            ser_out_q <= 1'b0;
            ser_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            ser_out_q <= ser_out_d;
            ser_vld_q <= ser_vld_d;
        end
    end

`ifdef MUXREG_PARITY_EN
    logic parity_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^q_next;
        end
    end

    assign parity = parity_q;
`else
    logic unused_q_next;
    assign unused_q_next = ^q_next;
`endif

    assign ser_out = ser_out_q;
    assign ser_vld = ser_vld_q;
    assign busy    = (state_q == UNLOAD);

endmodule

// File: tb/tb_mux_dff_reg.sv
// Directed self-checking bench for mux_dff_reg (WIDTH=8, NUM_SRC=4).
module tb_mux_dff_reg;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_SRC = 4;

    logic                     CLK = 1'b0;
    logic                     CLR;
    logic [NUM_SRC*WIDTH-1:0] src;
    logic [1:0]               sel_a, sel_b;
    logic                     sel_gate;
    logic [1:0]               mode;
    logic                     ser_in;
    logic                     unload;
    logic [WIDTH-1:0]         q;
    logic                     ser_out, ser_vld, busy;
`ifdef MUXREG_PARITY_EN
    logic                     parity;
`endif

    int tests = 0;
    int fails = 0;

    mux_dff_reg #(
        .WIDTH  (WIDTH),
        .NUM_SRC(NUM_SRC)
    ) dut (
        .CLK     (CLK),
        .CLR     (CLR),
        .src     (src),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .sel_gate(sel_gate),
        .mode    (mode),
        .ser_in  (ser_in),
        .unload  (unload),
        .q       (q),
`ifdef MUXREG_PARITY_EN
        .parity  (parity),
`endif
        .ser_out (ser_out),
        .ser_vld (ser_vld),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] pat;
        int pulses;

        CLR = 1'b1; src = '0; sel_a = '0; sel_b = '0; sel_gate = 1'b0;
        mode = 2'b00; ser_in = 1'b0; unload = 1'b0;
        tick();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vld", ser_vld, 0);
        chk("rst_sout", ser_out, 0);

        // LOAD with gated select LSB
        CLR = 1'b0;
        src = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        sel_a = 2'b10; sel_b = 2'b01; sel_gate = 1'b0; mode = 2'b01;
        tick();
        chk("load_gate0", q, 8'hC2);
        sel_gate = 1'b1;
        tick();
        chk("load_gate1", q, 8'hD3);
        mode = 2'b00;
        tick();
        chk("hold", q, 8'hD3);

        // Clear from a non-zero value
        CLR = 1'b1;
        tick();
        chk("clr_q", q, 0);
        chk("clr_busy", busy, 0);
        chk("clr_vld", ser_vld, 0);
        CLR = 1'b0;

        // Shifts
        sel_a = 2'b00; sel_b = 2'b00; sel_gate = 1'b0;
        src = {8'hD3, 8'hC2, 8'hB1, 8'h81}; mode = 2'b01;
        tick();
        chk("load81", q, 8'h81);
        mode = 2'b10; ser_in = 1'b0;
        tick();
        chk("shr", q, 8'h40);
        mode = 2'b11; ser_in = 1'b1;
        tick();
        chk("shl", q, 8'h81);

        // Unload A5 while LOAD is held on a different source value
        src[7:0] = 8'hA5; mode = 2'b01;
        tick();
        chk("loadA5", q, 8'hA5);
`ifdef MUXREG_PARITY_EN
        chk("parA5", parity, 0);
`endif
        pat = 8'hA5;
        src[7:0] = 8'h3C; unload = 1'b1;
        tick();
        chk("ul0_vld", ser_vld, 1);
        chk("ul0_sout", ser_out, pat[0]);
        chk("ul0_busy", busy, 1);
        chk("ul0_q", q, 8'hA5);
        for (int k = 1; k < 8; k++) begin
            unload = (k == 3);
            tick();
            chk("ul_vld", ser_vld, 1);
            chk("ul_sout", ser_out, pat[k]);
            chk("ul_busy", busy, 1);
            chk("ul_q", q, 8'hA5);
        end
        unload = 1'b0;
        tick();
        chk("ul_end_vld", ser_vld, 0);
        chk("ul_end_busy", busy, 0);
        chk("ul_end_sout", ser_out, 0);
        chk("ul_end_q", q, 8'hA5);
        tick();
        chk("post_load", q, 8'h3C);

        // Abort with CLR during the 4th bit
        src[7:0] = 8'hA5;
        tick();
        mode = 2'b00; unload = 1'b1;
        tick();
        unload = 1'b0;
        tick();
        tick();
        tick();
        chk("ab_bit3", ser_out, pat[3]);
        chk("ab_vld3", ser_vld, 1);
        CLR = 1'b1;
        tick();
        chk("ab_busy", busy, 0);
        chk("ab_vld", ser_vld, 0);
        chk("ab_q", q, 0);
        CLR = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (ser_vld) pulses++;
        end
        chk("ab_nopulse", pulses, 0);
        chk("ab_busy2", busy, 0);

        // Back-to-back unloads with unload held high
        src[7:0] = 8'h07; mode = 2'b01;
        tick();
        chk("load07", q, 8'h07);
`ifdef MUXREG_PARITY_EN
        chk("par07", parity, 1);
`endif
        pat = 8'h07;
        mode = 2'b00; unload = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("b2b_vld", ser_vld, 1);
            chk("b2b_sout", ser_out, pat[k % 8]);
            chk("b2b_busy", busy, 1);
        end
        unload = 1'b0;
        tick();
        chk("b2b_end_vld", ser_vld, 0);
        chk("b2b_end_busy", busy, 0);
        chk("b2b_q", q, 8'h07);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
